// File: rtl/data_memory.sv
// Word-addressed MIPS data memory: synchronous write, combinational gated read, async clear.
// Optional DMEM_RANGE_CHECK_EN adds addr_err and blocks out-of-range accesses instead of wrapping.
module data_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic [DATA_WIDTH-1:0] read_data
`ifdef DMEM_RANGE_CHECK_EN
    ,
    output logic                  addr_err
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]      idx;
    logic                  addr_hi;
    logic                  in_range;
    logic                  wr_en;

    assign idx = address[IDX_W-1:0];

    // Any set bit above the index field means the word address is >= DEPTH.
    generate
        if (ADDR_WIDTH > IDX_W) begin : g_hi
            assign addr_hi = |address[ADDR_WIDTH-1:IDX_W];
        end else begin : g_no_hi
            assign addr_hi = 1'b0;
        end
    endgenerate

`ifdef DMEM_RANGE_CHECK_EN
    assign in_range = ~addr_hi;
    assign addr_err = ~reset & (mem_read | mem_write) & addr_hi;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = addr_hi;
    assign in_range       = 1'b1;
`endif

    assign wr_en = mem_write & in_range;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[idx] <= write_data;
        end
    end

    assign read_data = (mem_read & in_range) ? mem_q[idx] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus randomized traffic vs. an array model.
module tb_data_memory;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] address;
    logic [DW-1:0] write_data;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] read_data;
`ifdef DMEM_RANGE_CHECK_EN
    logic          addr_err;
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] model [DEPTH];

    data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .write_data (write_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .read_data  (read_data)
`ifdef DMEM_RANGE_CHECK_EN
        ,
        .addr_err   (addr_err)
`endif
    );

    always #25 clk = ~clk;

    function automatic bit addr_ok(input logic [AW-1:0] a);
        return !RANGE_CHK || (a < DEPTH);
    endfunction

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a, input logic rd);
        if (!rd || !addr_ok(a)) return '0;
        return model[a % DEPTH];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // Advance one rising edge, apply the write rule to the model, then move off the edge.
    task automatic tick();
        @(posedge clk);
        if (!reset && mem_write && addr_ok(address))
            model[address % DEPTH] = write_data;
        #5;
    endtask

    task automatic cmp(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cmp_rd(input string tag);
        #1;
        cmp(tag, read_data, exp_read(address, mem_read));
`ifdef DMEM_RANGE_CHECK_EN
        cmp({tag, "_err"}, {31'b0, addr_err},
            {31'b0, !reset && (mem_read || mem_write) && !addr_ok(address)});
`endif
    endtask

    initial begin
        reset = 1'b1; address = '0; write_data = '0; mem_read = 1'b1; mem_write = 1'b0;
        clear_model();
        cmp_rd("reset_state");
        #10 reset = 1'b0;
        cmp_rd("after_release");

        // Write then read
        tick();
        address = 5; write_data = 7; mem_write = 1'b1; mem_read = 1'b0;
        tick(); tick();
        mem_write = 1'b0; mem_read = 1'b1;
        cmp_rd("wr_rd_same_cycle");
        cmp("wr_rd_value", read_data, 32'd7);
        tick(); cmp_rd("wr_rd_stable1");
        tick(); cmp_rd("wr_rd_stable2");

        // Read gating without clock edge
        mem_read = 1'b0; cmp_rd("gate_off");
        cmp("gate_off_zero", read_data, 32'd0);
        mem_read = 1'b1; cmp_rd("gate_on");
        cmp("gate_on_value", read_data, 32'd7);

        // Async reset clears
        address = 10; write_data = 32'hDEADBEEF; mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
        cmp_rd("pre_reset_val");
        #10 reset = 1'b1; clear_model();
        cmp_rd("reset_immediate");
        cmp("reset_immediate_zero", read_data, 32'd0);
        #5 reset = 1'b0;
        cmp_rd("reset_released");
        address = 5; cmp_rd("reset_word5");

        // Same-cycle read/write, no bypass
        tick();
        address = 3; write_data = 32'h11; mem_write = 1'b1;
        tick();
        write_data = 32'h22;
        cmp_rd("rw_before_edge");
        cmp("rw_before_old", read_data, 32'h11);
        tick();
        mem_write = 1'b0;
        cmp_rd("rw_after_edge");
        cmp("rw_after_new", read_data, 32'h22);

        // Isolation and wrap
        reset = 1'b1; clear_model(); #2 reset = 1'b0;
        tick();
        address = 0;   write_data = 32'hA; mem_write = 1'b1; tick();
        address = 255; write_data = 32'hB; tick();
        mem_write = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            address = i;
            cmp_rd($sformatf("iso_w%0d", i));
        end
        address = 256;
        cmp_rd("wrap_256_read");
        cmp("wrap_256_value", read_data, RANGE_CHK ? 32'h0 : 32'hA);
        write_data = 32'h55; mem_write = 1'b1;
        tick();
        mem_write = 1'b0; address = 0;
        cmp_rd("wrap_256_word0");

        // Write disabled
        address = 5; write_data = 32'h1234; mem_write = 1'b1; tick();
        mem_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            write_data = (i % 2 == 0) ? 32'hFFFF : 32'h0;
            tick();
        end
        cmp_rd("wdis_word5");
        cmp("wdis_value", read_data, 32'h1234);

        // Write coinciding with reset is discarded
        address = 7; write_data = 32'h99; mem_write = 1'b1; reset = 1'b1; clear_model();
        tick();
        reset = 1'b0; mem_write = 1'b0;
        cmp_rd("reset_wins");
        cmp("reset_wins_zero", read_data, 32'h0);

        // Randomized traffic against the array model
        for (int n = 0; n < 400; n++) begin
            address    = $urandom_range(0, 15) + (($urandom_range(0, 7) == 0) ? 256 * $urandom_range(1, 3) : 0);
            write_data = $urandom;
            mem_write  = $urandom_range(0, 1) == 1;
            mem_read   = $urandom_range(0, 1) == 1;
            cmp_rd($sformatf("rand_%0d", n));
            tick();
        end
        mem_write = 1'b0; mem_read = 1'b1;
        for (int i = 0; i < 16; i++) begin
            address = i;
            cmp_rd($sformatf("rand_final_w%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-organised data memory for the MIPS datapath, used in the MEM stage.
- Writes are synchronous on the rising clock edge when mem_write is high.
- Reads are combinational when mem_read is high.
- Asynchronous active-high reset clears the whole array, giving the core a known zeroed data segment.

Parameters:
- DATA_WIDTH, 32: width of each memory word and of the data ports.
- ADDR_WIDTH, 32: width of the address port.
- DEPTH, 256: number of words; must be a power of two, at least 2.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- reset  input  1  asynchronous, active-high; clears the memory array.
- address  input  ADDR_WIDTH  word index (not a byte address); address N selects word N.
- write_data  input  DATA_WIDTH  data stored when mem_write is high.
- mem_read  input  1  read enable.
- mem_write  input  1  write enable.
- read_data  output  DATA_WIDTH  word at address while mem_read=1; otherwise 0.

Behaviour:
- Storage: DEPTH words of DATA_WIDTH bits.
- Index: the low log2(DEPTH) bits of address select the word; higher address bits are ignored, so addresses wrap modulo DEPTH.
- Reset assertion: every word is cleared to 0 immediately, without waiting for a clock edge.
  - read_data therefore reads 0 while reset is high.
  - No write occurs while reset is high, even on a clock edge.
- Reset release: memory holds zeros until written.
- Write: on a rising clk edge with reset=0 and mem_write=1, mem[index] <= write_data.
  - Single-cycle write; no other word is affected.
- Read: read_data = mem[index] when mem_read=1, else all zeros.
  - Purely combinational; zero-cycle latency.
  - Follows address and memory contents continuously.
- Simultaneous mem_read=1 and mem_write=1 to the same index:
  - Before the edge, read_data shows the old value.
  - After the edge, read_data shows write_data.
  - There is no write-through bypass within the cycle.
- mem_write=0: memory contents are unchanged regardless of address and write_data activity.
- Reset mid-operation: a write whose edge coincides with reset assertion is discarded; reset wins.
- No handshake: every write completes in one cycle and every read is valid within the same cycle.
- X or undefined control inputs are not supported; the bench drives defined levels.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- When defined:
  - Adds output port addr_err (1 bit).
  - addr_err is combinationally 1 when (mem_read or mem_write) is high and address >= DEPTH; otherwise 0.
  - Out-of-range writes are suppressed, so memory is unchanged.
  - Out-of-range reads return 0.
  - addr_err is 0 during reset.
- When not defined:
  - The addr_err port does not exist.
  - Addresses wrap modulo DEPTH as described above.

Test Plan:
- Write then read: reset pulse; address=5, write_data=7, mem_write=1, mem_read=0 for 2 clocks (50 ns period); then mem_write=0, mem_read=1, address=5 -> read_data=7 within the same cycle and stable for 2 clocks.
- Read gating: after the write above, mem_read=0, address=5 -> read_data=0; raising mem_read -> read_data=7 with no clock edge required.
- Reset clears: write 0xDEADBEEF to word 10; assert reset asynchronously mid-cycle -> read_data (mem_read=1, address=10) is 0 immediately; after release it is still 0.
- Same-cycle read/write: word 3 holds 0x11; mem_read=1, mem_write=1, address=3, write_data=0x22 -> read_data=0x11 before the edge and 0x22 after it.
- Isolation and wrap:
  - Write 0xA to word 0 and 0xB to word 255; all other words read 0.
  - Without the macro, address=256 reads 0xA.
  - With DMEM_RANGE_CHECK_EN, address=256 gives addr_err=1 and read_data=0, and a write to 256 leaves word 0 = 0xA.
- Write disabled: mem_write=0, address=5, write_data=0xFFFF toggled over 4 clocks -> word 5 keeps its prior value.
